// File: rtl/div_16by8_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_APPROX_EN to skip the APPROX_BITS quotient LSBs (shorter CALC phase).
module div_16by8_seq #(
    parameter int DW          = 16,
    parameter int VW          = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

`ifdef DIV_APPROX_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif

    localparam int ITERS = APPROX_EN ? (DW - APPROX_BITS) : DW;
    localparam int CW    = $clog2(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] p_q, p_d;
    logic [DW-1:0] quo_q, quo_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   p_sh;
    logic          ge;
    logic [DW-1:0] q_sh;
    logic          last_iter;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // The partial remainder is always below the divisor, so VW bits hold it;
    // only the shifted trial value needs the extra bit.
    assign p_sh      = {p_q, dvd_q[DW-1]};
    assign ge        = (p_sh >= {1'b0, dvs_q});
    assign q_sh      = {quo_q[DW-2:0], ge};
    assign last_iter = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        p_d   = p_q;
        quo_d = quo_q;
        dbz_d = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        quo_d = '1;
                        p_d   = dividend[VW-1:0];
                        dbz_d = 1'b1;
                    end else begin
                        quo_d = '0;
                        p_d   = '0;
                        dbz_d = 1'b0;
                    end
                end
            end
            S_CALC: begin
                p_d   = ge ? VW'(p_sh - {1'b0, dvs_q}) : p_sh[VW-1:0];
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                // Approximate mode leaves the skipped quotient LSBs at zero
                quo_d = (APPROX_EN && last_iter) ? (q_sh << APPROX_BITS) : q_sh;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            p_q   <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            p_q   <= p_d;
            quo_q <= quo_d;
            dbz_q <= dbz_d;
        end
    end

    // Operand holding registers carry data only
    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        dvs_q <= dvs_d;
    end

    assign quotient    = quo_q;
    assign remainder   = p_q;
    assign div_by_zero = dbz_q;

endmodule
